// File: rtl/debug_dump_sequencer.sv
// rtl/debug_dump_sequencer.sv - serialises PC, register bank and a data-memory window onto the UART after halt
module debug_dump_sequencer #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_ADDR     = 32,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_pc_value,
  input  logic [NB_DATA-1:0] i_br_data,
  input  logic [NB_DATA-1:0] i_dm_data,
  input  logic               i_tx_done,
  output logic [NB_REG-1:0]  o_br_addr,
  output logic               o_br_read,
  output logic [NB_ADDR-1:0] o_dm_addr,
  output logic               o_dm_read,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_SEND, S_WAIT_TX, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {ITEM_PC, ITEM_REG, ITEM_MEM} item_t;

  // Terminal indices are compared explicitly so N_REGS = 2^NB_REG never relies on wrap.
  localparam logic [NB_REG-1:0]  LAST_REG = NB_REG'(N_REGS - 1);
  localparam logic [NB_ADDR-1:0] LAST_MEM = NB_ADDR'(N_MEM_WORDS - 1);

  state_t             r_state;
  item_t              r_item;
  logic [NB_DATA-1:0] r_shift;
  logic [1:0]         r_byte_cnt;

  assign o_tx_data = r_shift[7:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_item     <= ITEM_PC;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      o_br_addr  <= '0;
      o_br_read  <= 1'b0;
      o_dm_addr  <= '0;
      o_dm_read  <= 1'b0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_br_read  <= 1'b0;
      o_dm_read  <= 1'b0;
      o_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_item  <= ITEM_PC;
            o_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          case (r_item)
            ITEM_PC:  r_shift <= i_pc_value;
            ITEM_REG: r_shift <= i_br_data;
            default:  r_shift <= i_dm_data;
          endcase
          r_byte_cnt <= '0;
          o_tx_start <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (r_byte_cnt != 2'd3) begin
              r_shift    <= {8'h00, r_shift[NB_DATA-1:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
              o_tx_start <= 1'b1;
              r_state    <= S_SEND;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          // Strobes are registered here so they are high exactly during the READ cycle.
          case (r_item)
            ITEM_PC: begin
              r_item    <= ITEM_REG;
              o_br_addr <= '0;
              o_br_read <= 1'b1;
              r_state   <= S_READ;
            end
            ITEM_REG: begin
              if (o_br_addr == LAST_REG) begin
                r_item    <= ITEM_MEM;
                o_dm_addr <= '0;
                o_dm_read <= 1'b1;
              end else begin
                o_br_addr <= o_br_addr + NB_REG'(1);
                o_br_read <= 1'b1;
              end
              r_state <= S_READ;
            end
            default: begin
              if (o_dm_addr == LAST_MEM) begin
                o_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                o_dm_addr <= o_dm_addr + NB_ADDR'(1);
                o_dm_read <= 1'b1;
                r_state   <= S_READ;
              end
            end
          endcase
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb/tb_debug_dump_sequencer.sv - directed self-checking bench for debug_dump_sequencer
module tb_debug_dump_sequencer;

  localparam int NI = 3;  // 0: defaults, 1: NB_REG=2/N_REGS=4/N_MEM=2, 2: N_REGS=2/N_MEM=1

  logic        clk;
  logic        rst_n;
  int          cyc = 0;

  logic        go[NI];
  logic        inj[NI];
  logic        st[NI];
  logic        udone[NI];
  logic        spur[NI];
  logic        tx_done[NI];
  logic [31:0] br_data[NI];
  logic [31:0] dm_data[NI];
  logic [4:0]  br_addr[NI];
  logic [1:0]  b_br_addr;
  logic        br_rd[NI];
  logic [31:0] dm_addr[NI];
  logic        dm_rd[NI];
  logic [7:0]  tx_data[NI];
  logic        tx_start[NI];
  logic        busy[NI];
  logic        done[NI];

  int          n_tests = 0;
  int          n_fail  = 0;

  int          dly[NI];
  int          ucnt[NI];
  int          spur_at[NI];
  int          restart_at[NI];
  logic        br_pv[NI];
  logic [4:0]  br_pa[NI];
  logic        dm_pv[NI];
  logic [31:0] dm_pa[NI];

  int          nbytes[NI];
  int          nbr[NI];
  int          ndm[NI];
  int          ndone[NI];
  int          overlap[NI];
  int          first_cyc[NI];
  int          done_cyc[NI];
  int          busy_fall[NI];
  logic        busy_prev[NI];
  logic [7:0]  bytes[NI][300];
  logic [4:0]  br_log[NI][40];
  logic [31:0] dm_log[NI][40];

  for (genvar g = 0; g < NI; g++) begin : g_drv
    assign st[g]      = go[g] | inj[g];
    assign tx_done[g] = udone[g] | spur[g];
  end
  assign br_addr[1] = {3'b000, b_br_addr};

  debug_dump_sequencer u_dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(st[0]), .i_pc_value(32'h1234_5678),
    .i_br_data(br_data[0]), .i_dm_data(dm_data[0]), .i_tx_done(tx_done[0]),
    .o_br_addr(br_addr[0]), .o_br_read(br_rd[0]), .o_dm_addr(dm_addr[0]), .o_dm_read(dm_rd[0]),
    .o_tx_data(tx_data[0]), .o_tx_start(tx_start[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  debug_dump_sequencer #(.NB_REG(2), .N_REGS(4), .N_MEM_WORDS(2)) u_dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(st[1]), .i_pc_value(32'h1234_5678),
    .i_br_data(br_data[1]), .i_dm_data(dm_data[1]), .i_tx_done(tx_done[1]),
    .o_br_addr(b_br_addr), .o_br_read(br_rd[1]), .o_dm_addr(dm_addr[1]), .o_dm_read(dm_rd[1]),
    .o_tx_data(tx_data[1]), .o_tx_start(tx_start[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  debug_dump_sequencer #(.N_REGS(2), .N_MEM_WORDS(1)) u_dut_c (
    .i_clock(clk), .i_reset(rst_n), .i_start(st[2]), .i_pc_value(32'h1234_5678),
    .i_br_data(br_data[2]), .i_dm_data(dm_data[2]), .i_tx_done(tx_done[2]),
    .o_br_addr(br_addr[2]), .o_br_read(br_rd[2]), .o_dm_addr(dm_addr[2]), .o_dm_read(dm_rd[2]),
    .o_tx_data(tx_data[2]), .o_tx_start(tx_start[2]), .o_busy(busy[2]), .o_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, memory read-port models and UART done model, all on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (tx_start[i]) begin
        if (nbytes[i] < 300) bytes[i][nbytes[i]] = tx_data[i];
        if (nbytes[i] == 0) first_cyc[i] = cyc;
        nbytes[i]++;
      end
      if (br_rd[i]) begin
        if (nbr[i] < 40) br_log[i][nbr[i]] = br_addr[i];
        nbr[i]++;
      end
      if (dm_rd[i]) begin
        if (ndm[i] < 40) dm_log[i][ndm[i]] = dm_addr[i];
        ndm[i]++;
      end
      if (br_rd[i] && dm_rd[i]) overlap[i]++;
      if (done[i]) begin
        ndone[i]++;
        done_cyc[i] = cyc;
      end
      if (busy_prev[i] && !busy[i]) busy_fall[i] = cyc;
      busy_prev[i] = busy[i];

      br_data[i] = br_pv[i] ? 32'h100 + {27'd0, br_pa[i]} : 32'hDEAD_BEEF;
      br_pv[i]   = br_rd[i];
      br_pa[i]   = br_addr[i];
      dm_data[i] = dm_pv[i] ? 32'hA000 + dm_pa[i] : 32'hDEAD_BEEF;
      dm_pv[i]   = dm_rd[i];
      dm_pa[i]   = dm_addr[i];

      udone[i] = 1'b0;
      spur[i]  = tx_start[i] && (nbytes[i] == spur_at[i]);
      inj[i]   = tx_start[i] && (nbytes[i] == restart_at[i]);
      if (!rst_n) begin
        ucnt[i] = 0;
      end else begin
        if (ucnt[i] > 0) begin
          ucnt[i]--;
          if (ucnt[i] == 0) udone[i] = 1'b1;
        end
        if (tx_start[i]) ucnt[i] = dly[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      nbytes[i] = 0; nbr[i] = 0; ndm[i] = 0; ndone[i] = 0; overlap[i] = 0;
      first_cyc[i] = -1; done_cyc[i] = -1; busy_fall[i] = -1;
    end
  endtask

  task automatic pulse_start(input int i, output int p);
    @(negedge clk);
    go[i] = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    go[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int t = 0;
    while (ndone[i] == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("done_within_budget", 32'(t < budget), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  function automatic logic [31:0] exp_word(input int i, input int w);
    int nr;
    nr = (i == 0) ? 32 : (i == 1) ? 4 : 2;
    if (w == 0) return 32'h1234_5678;
    if (w <= nr) return 32'h100 + 32'(w - 1);
    return 32'hA000 + 32'(w - 1 - nr);
  endfunction

  task automatic check_bytes(input int i, input int n);
    logic [31:0] w;
    for (int b = 0; b < n; b++) begin
      w = exp_word(i, b / 4) >> (8 * (b % 4));
      check($sformatf("byte%0d_%0d", i, b), {24'd0, bytes[i][b]}, {24'd0, w[7:0]});
    end
  endtask

  initial begin
    int p;
    int t;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      go[i] = 1'b0; ucnt[i] = 0; spur_at[i] = -1; restart_at[i] = -1;
      br_pv[i] = 1'b0; dm_pv[i] = 1'b0; busy_prev[i] = 1'b0;
    end
    dly[0] = 10; dly[1] = 1; dly[2] = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start[0]}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data[0]}, 32'd0);
    check("rst_br_addr", {27'd0, br_addr[0]}, 32'd0);
    check("rst_dm_addr", dm_addr[0], 32'd0);
    check("rst_done", {31'd0, done[0]}, 32'd0);
    rst_n = 1'b1;

    // Full default dump with a re-start at byte 50 and a spurious done tick during SEND.
    clear_mon();
    spur_at[0] = 8;
    restart_at[0] = 50;
    pulse_start(0, p);
    wait_done(0, 5000);
    check("a_nbytes", 32'(nbytes[0]), 32'd260);
    check("a_ndone", 32'(ndone[0]), 32'd1);
    check("a_first_start", 32'(first_cyc[0]), 32'(p + 2));
    check("a_done_cycle", 32'(done_cyc[0]), 32'(p + 65 * 47));
    check("a_busy_fall", 32'(busy_fall[0]), 32'(p + 65 * 47 + 1));
    check_bytes(0, 260);
    check("a_nbr", 32'(nbr[0]), 32'd32);
    check("a_ndm", 32'(ndm[0]), 32'd32);
    check("a_overlap", 32'(overlap[0]), 32'd0);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("a_br_addr%0d", k), {27'd0, br_log[0][k]}, 32'(k));
      check($sformatf("a_dm_addr%0d", k), dm_log[0][k], 32'(k));
    end
    spur_at[0] = -1;
    restart_at[0] = -1;

    // Reset in the middle of a dump, then restart from the PC.
    clear_mon();
    pulse_start(0, p);
    t = 0;
    while (nbytes[0] < 101 && t < 6000) begin
      @(posedge clk);
      t++;
    end
    check("r_reached_byte100", 32'(t < 6000), 32'd1);
    check("r_pre_busy", {31'd0, busy[0]}, 32'd1);
    check("r_pre_br_addr", {27'd0, br_addr[0]}, 32'd24);
    #2 rst_n = 1'b0;
    #1;
    check("r_busy", {31'd0, busy[0]}, 32'd0);
    check("r_tx_start", {31'd0, tx_start[0]}, 32'd0);
    check("r_tx_data", {24'd0, tx_data[0]}, 32'd0);
    check("r_br_addr", {27'd0, br_addr[0]}, 32'd0);
    check("r_dm_addr", dm_addr[0], 32'd0);
    check("r_reads", {30'd0, br_rd[0], dm_rd[0]}, 32'd0);
    repeat (3) @(negedge clk);
    check("r_no_done", 32'(ndone[0]), 32'd0);
    rst_n = 1'b1;
    clear_mon();
    pulse_start(0, p);
    wait_done(0, 5000);
    check("r_first_byte", {24'd0, bytes[0][0]}, 32'h78);
    check("r_nbytes", 32'(nbytes[0]), 32'd260);
    check("r_ndone", 32'(ndone[0]), 32'd1);

    // Small config: 16 bytes, UART done after 1 cycle.
    clear_mon();
    pulse_start(2, p);
    wait_done(2, 500);
    check("c_nbytes", 32'(nbytes[2]), 32'd16);
    check("c_ndone", 32'(ndone[2]), 32'd1);
    check("c_done_cycle", 32'(done_cyc[2]), 32'(p + 44));
    check("c_busy_fall", 32'(busy_fall[2]), 32'(p + 45));
    check_bytes(2, 16);

    // Register index at full 2-bit range: regs 0..3 once each, then memory.
    clear_mon();
    pulse_start(1, p);
    wait_done(1, 500);
    check("b_nbytes", 32'(nbytes[1]), 32'd28);
    check("b_done_cycle", 32'(done_cyc[1]), 32'(p + 7 * 11));
    check("b_nbr", 32'(nbr[1]), 32'd4);
    check("b_ndm", 32'(ndm[1]), 32'd2);
    for (int k = 0; k < 4; k++) check($sformatf("b_br_addr%0d", k), {27'd0, br_log[1][k]}, 32'(k));
    for (int k = 0; k < 2; k++) check($sformatf("b_dm_addr%0d", k), dm_log[1][k], 32'(k));
    check_bytes(1, 28);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
